// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, execution units, tag width and reservation-station entry states.
`default_nettype none

package cpu_pkg;

  localparam int TAG_W      = 6;
  localparam int OP_W       = 6;
  localparam int EU_W       = 3;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_AND = 3'd3,
    ALU_NOT = 3'd4,
    ALU_XOR = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    EU_ADDER = 3'b000,
    EU_MULT  = 3'b001,
    EU_LOAD  = 3'b010,
    EU_STORE = 3'b011
  } exec_unit_e;

  typedef enum logic [1:0] {
    RS_FREE  = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2,
    RS_EXEC  = 2'd3
  } rs_state_e;

  // Entry index to its one-hot tag.
  function automatic logic [TAG_W-1:0] idx2tag(input logic [2:0] idx);
    return TAG_W'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_entry.sv
// One adder reservation-station entry: state FSM plus captured opcode, destination and operands.
`default_nettype none

module rs_entry
  import cpu_pkg::*;
#(
  parameter int               DATA_W = 32,
  parameter logic [TAG_W-1:0] MY_TAG = 6'b000001
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  alloc_i,
  input  logic [2:0]            op_i,
  input  logic [REG_ADDR_W-1:0] dest_i,
  input  logic [DATA_W-1:0]     vj_i,
  input  logic [TAG_W-1:0]      qj_i,
  input  logic [DATA_W-1:0]     vk_i,
  input  logic [TAG_W-1:0]      qk_i,
  input  logic                  dispatch_i,
  input  logic                  cdb_valid_i,
  input  logic [TAG_W-1:0]      cdb_tag_i,
  input  logic [DATA_W-1:0]     cdb_data_i,
  output rs_state_e             state_o,
  output logic [2:0]            op_o,
  output logic [REG_ADDR_W-1:0] dest_o,
  output logic [DATA_W-1:0]     vj_o,
  output logic [DATA_W-1:0]     vk_o,
  output logic                  finished_o
);

  rs_state_e             state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0]     vj_q, vj_d, vk_q, vk_d;
  logic [TAG_W-1:0]      qj_q, qj_d, qk_q, qk_d;
  logic                  hit_j, hit_k;

  // A cleared tag must never match, even if the bus carries tag 0.
  assign hit_j      = cdb_valid_i && (qj_q != '0) && (qj_q == cdb_tag_i);
  assign hit_k      = cdb_valid_i && (qk_q != '0) && (qk_q == cdb_tag_i);
  assign finished_o = (state_q == RS_EXEC) && cdb_valid_i && (cdb_tag_i == MY_TAG);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dest_d  = dest_q;
    vj_d    = vj_q;
    qj_d    = qj_q;
    vk_d    = vk_q;
    qk_d    = qk_q;
    case (state_q)
      RS_FREE: begin
        if (alloc_i) begin
          op_d    = op_i;
          dest_d  = dest_i;
          vj_d    = vj_i;
          qj_d    = qj_i;
          vk_d    = vk_i;
          qk_d    = qk_i;
          state_d = ((qj_i == '0) && (qk_i == '0)) ? RS_READY : RS_WAIT;
        end
      end
      RS_WAIT: begin
        if (hit_j) begin
          vj_d = cdb_data_i;
          qj_d = '0;
        end
        if (hit_k) begin
          vk_d = cdb_data_i;
          qk_d = '0;
        end
        if ((hit_j || (qj_q == '0)) && (hit_k || (qk_q == '0))) state_d = RS_READY;
      end
      RS_READY: begin
        if (dispatch_i) state_d = RS_EXEC;
      end
      RS_EXEC: begin
        if (finished_o) begin
          state_d = RS_FREE;
          op_d    = '0;
          dest_d  = '0;
          vj_d    = '0;
          qj_d    = '0;
          vk_d    = '0;
          qk_d    = '0;
        end
      end
      default: state_d = RS_FREE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RS_FREE;
      op_q    <= '0;
      dest_q  <= '0;
      vj_q    <= '0;
      qj_q    <= '0;
      vk_q    <= '0;
      qk_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      vj_q    <= vj_d;
      qj_q    <= qj_d;
      vk_q    <= vk_d;
      qk_q    <= qk_d;
    end
  end

  assign state_o = state_q;
  assign op_o    = op_q;
  assign dest_o  = dest_q;
  assign vj_o    = vj_q;
  assign vk_o    = vk_q;

endmodule

`default_nettype wire

// File: rtl/adder_reservation_station.sv
// Adder reservation station: NUM_RS entries with lowest-index allocation, CDB bypass and
// single-outstanding dispatch to the adder under a valid/ready handshake.
`default_nettype none

module adder_reservation_station
  import cpu_pkg::*;
#(
  parameter int NUM_RS = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  issue,
  input  logic [OP_W-1:0]       operation,
  input  logic [EU_W-1:0]       execution_unit,
  input  logic [REG_ADDR_W-1:0] Dest_address,
  input  logic [REG_ADDR_W-1:0] A_address,
  input  logic [REG_ADDR_W-1:0] B_address,
  input  logic [DATA_W-1:0]     A_value,
  input  logic [DATA_W-1:0]     B_value,
  input  logic [TAG_W-1:0]      A_tag,
  input  logic [TAG_W-1:0]      B_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic [DATA_W-1:0]     cdb_data,
  input  logic                  ex_ready,
  output logic                  adder_available,
  output logic [TAG_W-1:0]      adder_RS_available,
  output logic [TAG_W-1:0]      RS_issued,
  output logic [TAG_W-1:0]      RS_executing_adder,
  output logic [TAG_W-1:0]      RS_finished,
  output logic                  ex_valid,
  output logic [2:0]            ex_op,
  output logic [DATA_W-1:0]     ex_a,
  output logic [DATA_W-1:0]     ex_b,
  output logic [TAG_W-1:0]      ex_tag,
  output logic                  issue_error
);

  rs_state_e             state_w [NUM_RS];
  logic [2:0]            op_w    [NUM_RS];
  logic [REG_ADDR_W-1:0] dest_w  [NUM_RS];
  logic [DATA_W-1:0]     vj_w    [NUM_RS];
  logic [DATA_W-1:0]     vk_w    [NUM_RS];
  logic [NUM_RS-1:0]     alloc_w, dispatch_w, finished_w;

  logic                  free_found, ready_found, exec_busy;
  logic [2:0]            free_idx, ready_idx, sel_idx;
  logic                  issue_ok, ex_fire;
  logic                  byp_a, byp_b;
  logic [DATA_W-1:0]     vj_in, vk_in;
  logic [TAG_W-1:0]      qj_in, qk_in;
  logic                  hold_q, hold_d;
  logic [2:0]            hold_idx_q, hold_idx_d;

  // Operands produced on the CDB in the issue cycle are captured directly.
  assign byp_a = cdb_valid && (A_tag != '0) && (A_tag == cdb_tag);
  assign byp_b = cdb_valid && (B_tag != '0) && (B_tag == cdb_tag);
  assign vj_in = byp_a ? cdb_data : A_value;
  assign qj_in = byp_a ? '0 : A_tag;
  assign vk_in = byp_b ? cdb_data : B_value;
  assign qk_in = (byp_b || (operation[2:0] == ALU_NOT)) ? '0 : B_tag;

  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    exec_busy   = 1'b0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (state_w[i] == RS_FREE) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
      if (state_w[i] == RS_READY) begin
        ready_found = 1'b1;
        ready_idx   = 3'(i);
      end
      if (state_w[i] == RS_EXEC) exec_busy = 1'b1;
    end
  end

  assign issue_ok = issue && free_found && (execution_unit == EU_ADDER);

  // An offer not yet accepted stays pinned to its entry so the payload cannot change under it.
  assign sel_idx  = hold_q ? hold_idx_q : ready_idx;
  assign ex_valid = !exec_busy && (hold_q || ready_found);
  assign ex_fire  = ex_valid && ex_ready;
  assign ex_tag   = ex_valid ? idx2tag(sel_idx) : '0;

  always_comb begin
    ex_op = '0;
    ex_a  = '0;
    ex_b  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (ex_valid && (sel_idx == 3'(i))) begin
        ex_op = op_w[i];
        ex_a  = vj_w[i];
        ex_b  = vk_w[i];
      end
    end
  end

  assign hold_d     = ex_valid && !ex_ready;
  assign hold_idx_d = sel_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end

  for (genvar i = 0; i < NUM_RS; i++) begin : g_entry
    assign alloc_w[i]    = issue_ok && (free_idx == 3'(i));
    assign dispatch_w[i] = ex_fire && (sel_idx == 3'(i));

    rs_entry #(
      .DATA_W (DATA_W),
      .MY_TAG (TAG_W'(1 << i))
    ) u_entry (
      .clock_i     (clock),
      .reset_n_i   (reset_n),
      .alloc_i     (alloc_w[i]),
      .op_i        (operation[2:0]),
      .dest_i      (Dest_address),
      .vj_i        (vj_in),
      .qj_i        (qj_in),
      .vk_i        (vk_in),
      .qk_i        (qk_in),
      .dispatch_i  (dispatch_w[i]),
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .cdb_data_i  (cdb_data),
      .state_o     (state_w[i]),
      .op_o        (op_w[i]),
      .dest_o      (dest_w[i]),
      .vj_o        (vj_w[i]),
      .vk_o        (vk_w[i]),
      .finished_o  (finished_w[i])
    );
  end

  // Entry i owns tag bit i, so per-entry flags map straight onto tag bits.
  assign adder_available    = free_found;
  assign adder_RS_available = free_found ? idx2tag(free_idx) : '0;
  assign RS_issued          = (reset_n && issue_ok) ? idx2tag(free_idx) : '0;
  assign issue_error        = reset_n && issue && !issue_ok;
  assign RS_executing_adder = ex_fire ? ex_tag : '0;
  assign RS_finished        = TAG_W'(finished_w);

  logic dest_unused;
  logic inputs_unused;
  always_comb begin
    dest_unused = 1'b0;
    for (int i = 0; i < NUM_RS; i++) dest_unused = dest_unused ^ (^dest_w[i]);
  end
  assign inputs_unused = ^{operation[OP_W-1:3], A_address, B_address};

endmodule

`default_nettype wire

// File: tb/tb_adder_reservation_station.sv
// Directed, table-driven bench for adder_reservation_station with hand-written reset sequences.
`default_nettype none

module tb_adder_reservation_station;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue = 1'b0;
  logic [5:0]  operation = '0;
  logic [2:0]  execution_unit = '0;
  logic [4:0]  Dest_address = 5'd3, A_address = 5'd1, B_address = 5'd2;
  logic [31:0] A_value = '0, B_value = '0, cdb_data = '0;
  logic [5:0]  A_tag = '0, B_tag = '0, cdb_tag = '0;
  logic        cdb_valid = 1'b0, ex_ready = 1'b0;
  logic        adder_available, ex_valid, issue_error;
  logic [5:0]  adder_RS_available, RS_issued, RS_executing_adder, RS_finished, ex_tag;
  logic [2:0]  ex_op;
  logic [31:0] ex_a, ex_b;

  int checks = 0;
  int errors = 0;

  adder_reservation_station #(.NUM_RS(4), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .issue(issue), .operation(operation),
    .execution_unit(execution_unit), .Dest_address(Dest_address), .A_address(A_address),
    .B_address(B_address), .A_value(A_value), .B_value(B_value), .A_tag(A_tag), .B_tag(B_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .ex_ready(ex_ready),
    .adder_available(adder_available), .adder_RS_available(adder_RS_available),
    .RS_issued(RS_issued), .RS_executing_adder(RS_executing_adder), .RS_finished(RS_finished),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_tag(ex_tag),
    .issue_error(issue_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic iss; logic [5:0] op; logic [2:0] eu; logic [31:0] av; logic [5:0] at;
    logic [31:0] bv; logic [5:0] bt; logic cv; logic [5:0] ct; logic [31:0] cd; logic rdy;
  } in_t;
  typedef struct {
    logic avail; logic [5:0] rsav; logic [5:0] iss; logic err; logic exv; logic [5:0] extag;
    logic [2:0] exop; logic [31:0] exa; logic [31:0] exb; logic [5:0] exec; logic [5:0] fin;
  } exp_t;
  typedef struct { in_t i; exp_t e; } vec_t;

  vec_t tbl  [22];
  vec_t seqa [2];
  vec_t seqb [11];

  function automatic vec_t mk(input int iss, input int op, input int eu, input int av, input int at,
                              input int bv, input int bt, input int cv, input int ct, input int cd,
                              input int rdy, input int avail, input int rsav, input int is,
                              input int err, input int exv, input int extag, input int exop,
                              input int exa, input int exb, input int exec, input int fin);
    vec_t v;
    v.i.iss = 1'(iss); v.i.op = 6'(op); v.i.eu = 3'(eu); v.i.av = 32'(av); v.i.at = 6'(at);
    v.i.bv = 32'(bv); v.i.bt = 6'(bt); v.i.cv = 1'(cv); v.i.ct = 6'(ct); v.i.cd = 32'(cd);
    v.i.rdy = 1'(rdy);
    v.e.avail = 1'(avail); v.e.rsav = 6'(rsav); v.e.iss = 6'(is); v.e.err = 1'(err);
    v.e.exv = 1'(exv); v.e.extag = 6'(extag); v.e.exop = 3'(exop); v.e.exa = 32'(exa);
    v.e.exb = 32'(exb); v.e.exec = 6'(exec); v.e.fin = 6'(fin);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    issue = v.i.iss; operation = v.i.op; execution_unit = v.i.eu;
    A_value = v.i.av; A_tag = v.i.at; B_value = v.i.bv; B_tag = v.i.bt;
    cdb_valid = v.i.cv; cdb_tag = v.i.ct; cdb_data = v.i.cd; ex_ready = v.i.rdy;
    @(negedge clock);
    chk({nm, " adder_available"}, 32'(adder_available), 32'(v.e.avail));
    chk({nm, " adder_RS_available"}, 32'(adder_RS_available), 32'(v.e.rsav));
    chk({nm, " RS_issued"}, 32'(RS_issued), 32'(v.e.iss));
    chk({nm, " issue_error"}, 32'(issue_error), 32'(v.e.err));
    chk({nm, " ex_valid"}, 32'(ex_valid), 32'(v.e.exv));
    chk({nm, " RS_executing_adder"}, 32'(RS_executing_adder), 32'(v.e.exec));
    chk({nm, " RS_finished"}, 32'(RS_finished), 32'(v.e.fin));
    if (v.e.exv) begin
      chk({nm, " ex_tag"}, 32'(ex_tag), 32'(v.e.extag));
      chk({nm, " ex_op"}, 32'(ex_op), 32'(v.e.exop));
      chk({nm, " ex_a"}, ex_a, v.e.exa);
      chk({nm, " ex_b"}, ex_b, v.e.exb);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 iss op eu av   at    bv bt    cv ct    cd rdy | av rsav  iss   err exv tag  op a   b  exec  fin
    tbl[0]  = mk(0, 0, 0, 0,  'h00, 0, 'h00, 0, 'h00, 0,  1,  1, 'h01, 'h00, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[1]  = mk(1, 0, 0, 5,  'h00, 3, 'h00, 0, 'h00, 0,  1,  1, 'h01, 'h01, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[2]  = mk(0, 0, 0, 0,  'h00, 0, 'h00, 0, 'h00, 0,  1,  1, 'h02, 'h00, 0, 1, 'h01, 0, 5,  3, 'h01, 'h00);
    tbl[3]  = mk(0, 0, 0, 0,  'h00, 0, 'h00, 1, 'h01, 8,  1,  1, 'h02, 'h00, 0, 0, 0,    0, 0,  0, 'h00, 'h01);
    tbl[4]  = mk(0, 0, 0, 0,  'h00, 0, 'h00, 0, 'h00, 0,  1,  1, 'h01, 'h00, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[5]  = mk(1, 1, 0, 99, 'h02, 4, 'h00, 0, 'h00, 0,  1,  1, 'h01, 'h01, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[6]  = mk(0, 0, 0, 0,  'h00, 0, 'h00, 0, 'h00, 0,  1,  1, 'h02, 'h00, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[7]  = mk(0, 0, 0, 0,  'h00, 0, 'h00, 1, 'h02, 7,  1,  1, 'h02, 'h00, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[8]  = mk(0, 0, 0, 0,  'h00, 0, 'h00, 0, 'h00, 0,  1,  1, 'h02, 'h00, 0, 1, 'h01, 1, 7,  4, 'h01, 'h00);
    tbl[9]  = mk(0, 0, 0, 0,  'h00, 0, 'h00, 1, 'h01, 3,  1,  1, 'h02, 'h00, 0, 0, 0,    0, 0,  0, 'h00, 'h01);
    tbl[10] = mk(1, 0, 0, 0,  'h20, 1, 'h00, 0, 'h00, 0,  0,  1, 'h01, 'h01, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[11] = mk(1, 0, 0, 0,  'h20, 2, 'h00, 0, 'h00, 0,  0,  1, 'h02, 'h02, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[12] = mk(1, 0, 0, 0,  'h20, 3, 'h00, 0, 'h00, 0,  0,  1, 'h04, 'h04, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[13] = mk(1, 0, 0, 0,  'h20, 4, 'h00, 0, 'h00, 0,  0,  1, 'h08, 'h08, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[14] = mk(1, 0, 0, 0,  'h20, 5, 'h00, 0, 'h00, 0,  0,  0, 'h00, 'h00, 1, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[15] = mk(0, 0, 0, 0,  'h00, 0, 'h00, 0, 'h00, 0,  0,  0, 'h00, 'h00, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[16] = mk(0, 0, 0, 0,  'h00, 0, 'h00, 1, 'h20, 11, 0,  0, 'h00, 'h00, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[17] = mk(0, 0, 0, 0,  'h00, 0, 'h00, 0, 'h00, 0,  0,  0, 'h00, 'h00, 0, 1, 'h01, 0, 11, 1, 'h00, 'h00);
    tbl[18] = mk(0, 0, 0, 0,  'h00, 0, 'h00, 0, 'h00, 0,  1,  0, 'h00, 'h00, 0, 1, 'h01, 0, 11, 1, 'h01, 'h00);
    tbl[19] = mk(0, 0, 0, 0,  'h00, 0, 'h00, 0, 'h00, 0,  1,  0, 'h00, 'h00, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    tbl[20] = mk(1, 0, 0, 1,  'h00, 1, 'h00, 1, 'h01, 12, 1,  0, 'h00, 'h00, 1, 0, 0,    0, 0,  0, 'h00, 'h01);
    tbl[21] = mk(1, 0, 1, 1,  'h00, 1, 'h00, 0, 'h00, 0,  1,  1, 'h01, 'h00, 1, 1, 'h02, 0, 11, 2, 'h02, 'h00);

    seqa[0] = mk(1, 0, 0, 0,  'h04, 2, 'h00, 1, 'h04, 40, 1,  1, 'h01, 'h01, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    seqa[1] = mk(0, 0, 0, 0,  'h00, 0, 'h00, 0, 'h00, 0,  1,  1, 'h02, 'h00, 0, 1, 'h01, 0, 40, 2, 'h01, 'h00);

    seqb[0]  = mk(1, 0, 0, 0, 'h10, 9, 'h00, 0, 'h00, 0,  0,  1, 'h01, 'h01, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    seqb[1]  = mk(1, 5, 0, 1, 'h00, 2, 'h00, 0, 'h00, 0,  0,  1, 'h02, 'h02, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    seqb[2]  = mk(0, 0, 0, 0, 'h00, 0, 'h00, 1, 'h10, 6,  0,  1, 'h04, 'h00, 0, 1, 'h02, 5, 1,  2, 'h00, 'h00);
    seqb[3]  = mk(0, 0, 0, 0, 'h00, 0, 'h00, 0, 'h00, 0,  0,  1, 'h04, 'h00, 0, 1, 'h02, 5, 1,  2, 'h00, 'h00);
    seqb[4]  = mk(0, 0, 0, 0, 'h00, 0, 'h00, 0, 'h00, 0,  0,  1, 'h04, 'h00, 0, 1, 'h02, 5, 1,  2, 'h00, 'h00);
    seqb[5]  = mk(0, 0, 0, 0, 'h00, 0, 'h00, 0, 'h00, 0,  1,  1, 'h04, 'h00, 0, 1, 'h02, 5, 1,  2, 'h02, 'h00);
    seqb[6]  = mk(0, 0, 0, 0, 'h00, 0, 'h00, 1, 'h02, 3,  1,  1, 'h04, 'h00, 0, 0, 0,    0, 0,  0, 'h00, 'h02);
    seqb[7]  = mk(0, 0, 0, 0, 'h00, 0, 'h00, 0, 'h00, 0,  1,  1, 'h02, 'h00, 0, 1, 'h01, 0, 6,  9, 'h01, 'h00);
    seqb[8]  = mk(1, 4, 0, 7, 'h00, 0, 'h20, 0, 'h00, 0,  0,  1, 'h02, 'h02, 0, 0, 0,    0, 0,  0, 'h00, 'h00);
    seqb[9]  = mk(0, 0, 0, 0, 'h00, 0, 'h00, 1, 'h01, 0,  0,  1, 'h04, 'h00, 0, 0, 0,    0, 0,  0, 'h00, 'h01);
    seqb[10] = mk(0, 0, 0, 0, 'h00, 0, 'h00, 0, 'h00, 0,  1,  1, 'h01, 'h00, 0, 1, 'h02, 4, 7,  0, 'h02, 'h00);

    // In reset: issue must be ignored.
    issue = 1'b1;
    #1;
    chk("reset RS_issued", 32'(RS_issued), 32'h0);
    chk("reset issue_error", 32'(issue_error), 32'h0);
    chk("reset ex_valid", 32'(ex_valid), 32'h0);
    chk("reset adder_available", 32'(adder_available), 32'h1);
    issue = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int k = 0; k < 22; k++) run_vec(tbl[k], $sformatf("tbl%0d", k));

    // Asynchronous reset pulse between edges with entries busy.
    issue = 1'b0; cdb_valid = 1'b0; ex_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("pulse adder_available", 32'(adder_available), 32'h1);
    chk("pulse adder_RS_available", 32'(adder_RS_available), 32'h01);
    chk("pulse ex_valid", 32'(ex_valid), 32'h0);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int k = 0; k < 2; k++) run_vec(seqa[k], $sformatf("bypass%0d", k));

    // Entry 0 is now executing; reset it with its own tag on the CDB.
    issue = 1'b1; operation = '0; execution_unit = '0; A_tag = '0; B_tag = '0;
    cdb_valid = 1'b1; cdb_tag = 6'h01; cdb_data = 32'd5; ex_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("midexec ex_valid", 32'(ex_valid), 32'h0);
    chk("midexec RS_issued", 32'(RS_issued), 32'h0);
    chk("midexec issue_error", 32'(issue_error), 32'h0);
    chk("midexec RS_executing_adder", 32'(RS_executing_adder), 32'h0);
    chk("midexec RS_finished", 32'(RS_finished), 32'h0);
    chk("midexec adder_available", 32'(adder_available), 32'h1);
    chk("midexec adder_RS_available", 32'(adder_RS_available), 32'h01);
    issue = 1'b0;
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("stale cdb RS_finished", 32'(RS_finished), 32'h0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("stale cdb2 RS_finished", 32'(RS_finished), 32'h0);
    chk("stale cdb2 ex_valid", 32'(ex_valid), 32'h0);
    chk("stale cdb2 adder_RS_available", 32'(adder_RS_available), 32'h01);
    cdb_valid = 1'b0;
    @(posedge clock);
    #1;

    for (int k = 0; k < 11; k++) run_vec(seqb[k], $sformatf("hold%0d", k));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_reservation_station.md
ADDER_RESERVATION_STATION -- requirements
Module: adder_reservation_station

Interface
REQ-001 Parameter NUM_RS, default 4, number of adder reservation-station entries (1..6).
REQ-002 Parameter DATA_W, default 32, operand/result width.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 issue  in  1  instruction presented this cycle by the instruction queue.
REQ-006 operation  in  6  opcode; bits [2:0] select alu_add/sub/or/and/not/xor.
REQ-007 execution_unit  in  3  target unit; only ADDER (3'b000) is accepted.
REQ-008 Dest_address, A_address, B_address  in  5 each  register specifiers.
REQ-009 A_value, B_value  in  DATA_W each  register-file read data for A/B_address, same cycle.
REQ-010 A_tag, B_tag  in  6 each  register-status tag for A/B_address; 0 means value valid.
REQ-011 cdb_valid, cdb_tag, cdb_data  in  1/6/DATA_W  common data bus broadcast.
REQ-012 ex_ready  in  1  adder unit can accept an operation this cycle.
REQ-013 adder_available  out  1  at least one free entry.
REQ-014 adder_RS_available  out  6  one-hot tag of the lowest-index free entry; 0 if none.
REQ-015 RS_issued  out  6  one-hot tag of entry written this cycle, else 0.
REQ-016 RS_executing_adder  out  6  one-hot tag dispatched to adder this cycle, else 0.
REQ-017 RS_finished  out  6  one-hot tag whose result appeared on the CDB this cycle, else 0.
REQ-018 ex_valid, ex_op, ex_a, ex_b, ex_tag  out  1/3/DATA_W/DATA_W/6  dispatch to adder unit.
REQ-019 issue_error  out  1  issue rejected (no free entry or wrong execution_unit).

Function
REQ-020 Entry i SHALL own tag (1<<i); tags are one-hot, never 0.
REQ-021 Entry FSM SHALL be FREE -> WAIT -> READY -> EXEC -> FREE.
REQ-022 On issue with adder_available and execution_unit==ADDER, the lowest-index FREE entry SHALL capture op, Dest, Vj/Qj, Vk/Qk and enter WAIT, or READY if both tags are 0.
REQ-023 On issue otherwise, issue_error SHALL be 1 for that cycle and no entry SHALL change.
REQ-024 On cdb_valid, every WAIT entry whose Qj or Qk equals cdb_tag SHALL load cdb_data and clear that tag; a WAIT entry with both tags cleared SHALL move to READY next cycle.
REQ-025 CDB capture SHALL apply to operands being issued the same cycle (bypass): a matching A_tag/B_tag SHALL be replaced by cdb_data with tag 0.
REQ-026 At most one entry SHALL be in EXEC; when none is and ex_ready is 1, the lowest-index READY entry SHALL dispatch: ex_valid=1, ex_tag/op/a/b from entry, RS_executing_adder=its tag, state EXEC.
REQ-027 ex_valid SHALL be held with stable payload until ex_ready is sampled 1.
REQ-028 On cdb_valid with cdb_tag equal to the EXEC entry tag, RS_finished SHALL equal that tag for one cycle and the entry SHALL return to FREE the next edge.
REQ-029 A freed entry SHALL NOT be reallocated in the cycle it is freed; adder_available reflects it the following cycle.
REQ-030 operation[2:0]=alu_not SHALL ignore B: Qk forced 0.
REQ-031 adder_available and adder_RS_available SHALL be combinational from registered entry states only.

Reset
REQ-032 reset_n low SHALL force all entries FREE, all tags/values 0, ex_valid=0, RS_issued/RS_executing_adder/RS_finished=0, issue_error=0, immediately and regardless of clock.
REQ-033 Reset mid-EXEC SHALL discard the in-flight operation; a later CDB broadcast of its tag SHALL be ignored.
REQ-034 After deassertion adder_available=1 and adder_RS_available=6'b000001.

Structure
REQ-035 Opcode, execution-unit, tag-width and entry-state encodings SHALL live in shared package cpu_pkg, also used by instruction_queue.
REQ-036 One sub-module rs_entry SHALL hold a single entry's state and operands; the top SHALL instantiate NUM_RS and implement allocation and dispatch priority.

Verification
REQ-037 Issue add with A_tag=B_tag=0, A=5, B=3, ex_ready=1 -> RS_issued=000001, next cycle ex_valid with a=5,b=3; CDB tag 000001 data 8 -> RS_finished=000001, entry FREE.
REQ-038 Issue with A_tag=000010 -> WAIT; CDB tag 000010 data 7 -> ex_a=7 dispatched one cycle later.
REQ-039 Issue 4 times with no CDB -> adder_available=0, adder_RS_available=0; 5th issue -> issue_error=1, no state change.
REQ-040 Issue with A_tag=000100 while cdb_tag=000100 same cycle -> entry captures cdb_data, enters READY.
REQ-041 Two READY entries, ex_ready=0 for 3 cycles -> ex_valid/payload stable, lower index dispatched first.
REQ-042 reset_n low during EXEC -> all outputs 0, adder_available=1; subsequent CDB with old tag -> RS_finished stays 0.
